// File: rtl/neuron_io_driver.sv
`default_nettype none
// =============================================================================
// Module   : neuron_io_driver
// Function : Streams signed inputs MSB-first into the neuron wrapper SIPO, pulses
//            START, awaits DONE and reassembles the PISO result. Optional DONE
//            watchdog is enabled by defining NEURON_IO_DRIVER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module neuron_io_driver #(
  parameter int WIDTH          = 8,
  parameter int NUM_INPUTS     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] IN_VALUE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_VALUE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic             TIMEOUT_ERR,
  output logic             LOAD_IN,
  output logic             LOAD_VALUE_IN,
  output logic             SHIFT_OUT,
  input  logic             SHIFT_VALUE_OUT,
  input  logic             NEURON_READY,
  output logic             START,
  input  logic             DONE
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_RDY  = 3'd2,
    S_STRT      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_UNLOAD    = 3'd5,
    S_OUT       = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_load_sr;
  logic [WIDTH-1:0]   r_result;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [c_IDX_W-1:0] r_idx;
  logic               w_bit_last;
  logic               w_idx_last;
  logic               w_timeout;

  assign w_bit_last = (r_bit_cnt == c_BIT_LAST);
  assign w_idx_last = (r_idx == c_IDX_LAST);

`ifdef NEURON_IO_DRIVER_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_timeout_err;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_WAIT_DONE && !DONE) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign w_timeout   = (r_state == S_WAIT_DONE) && !DONE && (r_to_cnt == c_TO_LAST);
  assign TIMEOUT_ERR = r_timeout_err;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout            = 1'b0;
  assign TIMEOUT_ERR          = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    IN_READY    = 1'b0;
    LOAD_IN     = 1'b0;
    SHIFT_OUT   = 1'b0;
    START       = 1'b0;
    OUT_VALID   = 1'b0;
    case (r_state)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        LOAD_IN = 1'b1;
        // READY seen in the final load cycle skips the wait state entirely
        if (w_bit_last) begin
          w_state_nxt = NEURON_READY ? S_STRT : S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (NEURON_READY) begin
          w_state_nxt = S_STRT;
        end
      end
      S_STRT: begin
        START = 1'b1;
        if (!w_idx_last) begin
          w_state_nxt = S_IDLE;
        end else if (DONE) begin
          w_state_nxt = S_UNLOAD;
        end else begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (DONE) begin
          w_state_nxt = S_UNLOAD;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_UNLOAD: begin
        SHIFT_OUT = 1'b1;
        if (w_bit_last) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_load_sr <= '0;
      r_result  <= '0;
      r_bit_cnt <= '0;
      r_idx     <= '0;
    end else begin
      if (r_state == S_LOAD || r_state == S_UNLOAD) begin
        r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
      end else begin
        r_bit_cnt <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (IN_VALID) begin
            r_load_sr <= IN_VALUE;
          end
        end
        S_LOAD: begin
          r_load_sr <= {r_load_sr[WIDTH-2:0], 1'b0};
        end
        S_STRT: begin
          if (!w_idx_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (w_timeout) begin
            r_idx <= '0;
          end
        end
        S_UNLOAD: begin
          // First PISO bit sampled ends up as the MSB
          r_result <= {r_result[WIDTH-2:0], SHIFT_VALUE_OUT};
        end
        S_OUT: begin
          if (OUT_READY) begin
            r_idx <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign LOAD_VALUE_IN = (r_state == S_LOAD) && r_load_sr[WIDTH-1];
  assign OUT_VALUE     = r_result;
  assign BUSY          = (r_state != S_IDLE) || (r_idx != '0);

endmodule
`default_nettype wire

// File: tb/tb_neuron_io_driver.sv
`default_nettype none
// =============================================================================
// Module   : tb_neuron_io_driver
// Function : Randomised self-checking bench with a wrapper SIPO/PISO model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_neuron_io_driver;

  localparam int WIDTH      = 8;
  localparam int NUM_INPUTS = 2;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic [WIDTH-1:0] IN_VALUE;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] OUT_VALUE;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             BUSY;
  logic             TIMEOUT_ERR;
  logic             LOAD_IN;
  logic             LOAD_VALUE_IN;
  logic             SHIFT_OUT;
  logic             SHIFT_VALUE_OUT;
  logic             NEURON_READY;
  logic             START;
  logic             DONE;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;

  neuron_io_driver #(
    .WIDTH(WIDTH),
    .NUM_INPUTS(NUM_INPUTS),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .IN_VALUE(IN_VALUE),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .OUT_VALUE(OUT_VALUE),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .LOAD_IN(LOAD_IN),
    .LOAD_VALUE_IN(LOAD_VALUE_IN),
    .SHIFT_OUT(SHIFT_OUT),
    .SHIFT_VALUE_OUT(SHIFT_VALUE_OUT),
    .NEURON_READY(NEURON_READY),
    .START(START),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Wrapper model: SIPO fills at its LSB, PISO presents its MSB and loads on DONE
  logic [WIDTH-1:0] sipo = '0;
  logic [WIDTH-1:0] piso = '0;
  logic [WIDTH-1:0] next_result = '0;

  always @(posedge CLK) begin
    if (LOAD_IN) sipo <= {sipo[WIDTH-2:0], LOAD_VALUE_IN};
    if (DONE) piso <= next_result;
    else if (SHIFT_OUT) piso <= {piso[WIDTH-2:0], 1'b0};
    if (START) n_start <= n_start + 1;
  end
  assign SHIFT_VALUE_OUT = piso[WIDTH-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // rdy_on: first cycle after the input handshake with NEURON_READY high.
  // done_dly: cycles after the last START at which DONE pulses (0 = same cycle).
  task automatic run_txn(input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                         input int rdy_on0, input int rdy_on1, input int done_dly,
                         input int out_hold, input logic [WIDTH-1:0] res, input bit spur);
    logic [WIDTH-1:0] v [2];
    int rdy_on [2];
    int c, n_load, start_at, t, out_at, n_sh, first_sh, start_base, exp_start;
    v[0] = v0; v[1] = v1; rdy_on[0] = rdy_on0; rdy_on[1] = rdy_on1;
    next_result = res;
    start_base = n_start;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      check("in_ready_idle", IN_READY, 1);
      IN_VALUE = v[i]; IN_VALID = 1'b1; NEURON_READY = (rdy_on[i] == 0);
      tick();
      IN_VALID = 1'b0; IN_VALUE = WIDTH'($urandom);
      c = 1; n_load = 0; start_at = 0;
      while (start_at == 0 && c < 200) begin
        if (LOAD_IN) begin
          if (n_load < WIDTH) check("load_bit", LOAD_VALUE_IN, v[i][WIDTH-1-n_load]);
          n_load++;
        end
        if (START) start_at = c;
        NEURON_READY = (c >= rdy_on[i]);
        // a DONE before the final START must have no effect
        DONE = (spur && i == 0 && c == 3) || (START && i == NUM_INPUTS-1 && done_dly == 0);
        if (start_at == 0) begin
          tick();
          c++;
        end
      end
      exp_start = ((rdy_on[i] > WIDTH) ? rdy_on[i] : WIDTH) + 1;
      check("start_cycle", start_at, exp_start);
      check("load_cycles", n_load, WIDTH);
      check("sipo_at_start", sipo, v[i]);
      check("busy_strt", BUSY, 1);
      tick();
      DONE = 1'b0;
      check("start_one_cycle", START, 0);
      if (i < NUM_INPUTS-1) check("busy_open", BUSY, 1);
    end
    t = 1; out_at = 0; n_sh = 0; first_sh = 0;
    DONE = (done_dly == 1);
    while (out_at == 0 && t < done_dly + 100) begin
      if (SHIFT_OUT) begin
        n_sh++;
        if (first_sh == 0) first_sh = t;
      end
      if (OUT_VALID) out_at = t;
      else begin
        tick();
        t++;
        DONE = (t == done_dly);
      end
    end
    DONE = 1'b0;
    check("shift_first", first_sh, done_dly + 1);
    check("shift_cycles", n_sh, WIDTH);
    check("out_valid_cycle", out_at, done_dly + WIDTH + 1);
    check("start_count", n_start - start_base, NUM_INPUTS);
    for (int h = 0; h < out_hold; h++) begin
      check("out_valid_hold", OUT_VALID, 1);
      check("out_value_hold", OUT_VALUE, res);
      check("in_ready_out", IN_READY, 0);
      check("busy_out", BUSY, 1);
      tick();
    end
    check("out_value", OUT_VALUE, res);
    // Result and a fresh input offered together: only the result is taken
    OUT_READY = 1'b1; IN_VALID = 1'b1; IN_VALUE = WIDTH'($urandom);
    tick();
    OUT_READY = 1'b0; IN_VALID = 1'b0;
    check("out_valid_drop", OUT_VALID, 0);
    check("in_ready_after", IN_READY, 1);
    check("busy_after", BUSY, 0);
    check("no_load_after_out", LOAD_IN, 0);
  endtask

  initial begin
    int base, rdy_a, rdy_b, t;
    bit seen_ov;
    RSTN = 1'b0; IN_VALUE = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    NEURON_READY = 1'b0; DONE = 1'b0;
    tick(); tick();
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_value", OUT_VALUE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_start", START, 0);
    check("rst_load", LOAD_IN, 0);
    check("rst_shift", SHIFT_OUT, 0);
    check("rst_timeout", TIMEOUT_ERR, 0);
    RSTN = 1'b1;
    tick();

    run_txn(8'hA5, 8'h5A, 0, 0, 3, 0, 8'h3C, 1'b0);
    run_txn(8'h20, 8'hE0, WIDTH + 6, 0, 5, 10, 8'hC3, 1'b0);
    run_txn(8'h7F, 8'h80, 0, 0, 0, 1, 8'h81, 1'b1);

    // Asynchronous reset in the 4th load cycle
    IN_VALUE = 8'h5A; IN_VALID = 1'b1; NEURON_READY = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick(); tick(); tick();
    check("load_before_rst", LOAD_IN, 1);
    base = n_start;
    RSTN = 1'b0;
    #1;
    check("arst_in_ready", IN_READY, 1);
    check("arst_load", LOAD_IN, 0);
    check("arst_load_val", LOAD_VALUE_IN, 0);
    check("arst_start", START, 0);
    check("arst_shift", SHIFT_OUT, 0);
    check("arst_out_valid", OUT_VALID, 0);
    check("arst_out_value", OUT_VALUE, 0);
    check("arst_busy", BUSY, 0);
    tick(); tick();
    RSTN = 1'b1;
    tick();
    check("arst_no_start", n_start - base, 0);
    run_txn(8'h11, 8'h22, 0, 0, 2, 1, 8'h77, 1'b0);

    for (int n = 0; n < 16; n++) begin
      rdy_a = ($urandom_range(0, 3) == 0) ? $urandom_range(WIDTH + 1, WIDTH + 8) : $urandom_range(0, WIDTH);
      rdy_b = ($urandom_range(0, 3) == 0) ? $urandom_range(WIDTH + 1, WIDTH + 8) : $urandom_range(0, WIDTH);
      run_txn(WIDTH'($urandom), WIDTH'($urandom), rdy_a, rdy_b, $urandom_range(0, 10),
              $urandom_range(0, 5), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end

`ifdef NEURON_IO_DRIVER_TIMEOUT_EN
    NEURON_READY = 1'b1; DONE = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      IN_VALUE = WIDTH'($urandom); IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      for (int w = 0; w < 50 && !START; w++) tick();
      tick();
    end
    t = 1; seen_ov = 1'b0;
    while (!IN_READY && t < 100) begin
      if (OUT_VALID) seen_ov = 1'b1;
      tick();
      t++;
    end
    check("timeout_cycle", t, 17);
    check("timeout_err", TIMEOUT_ERR, 1);
    check("timeout_no_out", seen_ov, 0);
    check("timeout_busy", BUSY, 0);
`else
    t = 0; seen_ov = 1'b0;
    check("timeout_tied", TIMEOUT_ERR, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
